// File: rtl/dm_arbiter_pkg.sv
// Shared data-memory definitions: access op codes, winner tags and the
// alignment mask used by both dm and dm_arbiter.
package dm_arbiter_pkg;

    typedef enum logic [2:0] {
        DM_OP_WD = 3'd0,
        DM_OP_BS = 3'd1,
        DM_OP_BU = 3'd2,
        DM_OP_HS = 3'd3,
        DM_OP_HU = 3'd4
    } dm_op_e;

    typedef enum logic {
        WIN_A = 1'b0,
        WIN_B = 1'b1
    } winner_e;

    // Low address bits that must be zero for the given op.
    function automatic logic [1:0] dm_align_mask(input logic [2:0] op);
        case (op)
            DM_OP_WD:           return 2'b11;
            DM_OP_HS, DM_OP_HU: return 2'b01;
            default:            return 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/dm_arbiter.sv
// Two-port arbiter for the data memory: fixed priority to port A with a
// starvation guard for port B, misalignment rejection and registered responses.
module dm_arbiter
    import dm_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned CNT_W        = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_valid,
    input  logic        a_we,
    input  logic [31:0] a_addr,
    input  logic [31:0] a_wdata,
    input  logic [2:0]  a_op,
    output logic        a_ready,
    output logic        a_rvalid,
    output logic [31:0] a_rdata,
    output logic        a_err,
    input  logic        b_valid,
    input  logic        b_we,
    input  logic [31:0] b_addr,
    input  logic [31:0] b_wdata,
    input  logic [2:0]  b_op,
    output logic        b_ready,
    output logic        b_rvalid,
    output logic [31:0] b_rdata,
    output logic        b_err,
    output logic        dm_w,
    output logic        dm_r,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    output logic [2:0]  dm_op,
    input  logic [31:0] dm_rdata
);

    localparam logic [CNT_W-1:0] LP_LIMIT = CNT_W'(STARVE_LIMIT);

    logic             w_grant_a;
    logic             w_grant_b;
    logic             w_grant;
    logic             w_we;
    logic [31:0]      w_addr;
    logic [31:0]      w_wdata;
    logic [2:0]       w_op;
    logic             w_misaligned;

    logic [CNT_W-1:0] r_starve_cnt;
    winner_e          r_last_winner;
    logic             r_rsp_valid;
    logic [31:0]      r_a_rdata;
    logic [31:0]      r_b_rdata;
    logic             r_a_err;
    logic             r_b_err;

    always_comb begin
        w_grant_a = 1'b0;
        w_grant_b = 1'b0;
        if (!rst) begin
            if (a_valid && b_valid) begin
                if (r_starve_cnt >= LP_LIMIT) w_grant_b = 1'b1;
                else                          w_grant_a = 1'b1;
            end else if (a_valid) begin
                w_grant_a = 1'b1;
            end else if (b_valid) begin
                w_grant_b = 1'b1;
            end
        end
    end

    always_comb begin
        w_we    = 1'b0;
        w_addr  = '0;
        w_wdata = '0;
        w_op    = '0;
        if (w_grant_a) begin
            w_we    = a_we;
            w_addr  = a_addr;
            w_wdata = a_wdata;
            w_op    = a_op;
        end else if (w_grant_b) begin
            w_we    = b_we;
            w_addr  = b_addr;
            w_wdata = b_wdata;
            w_op    = b_op;
        end
        w_grant      = w_grant_a | w_grant_b;
        // A misaligned winner is still accepted, but never touches memory.
        w_misaligned = |(w_addr[1:0] & dm_align_mask(w_op));
        a_ready      = w_grant_a;
        b_ready      = w_grant_b;
        dm_w         = w_grant &  w_we & ~w_misaligned;
        dm_r         = w_grant & ~w_we & ~w_misaligned;
        dm_addr      = w_addr;
        dm_wdata     = w_wdata;
        dm_op        = w_op;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_starve_cnt  <= '0;
            r_last_winner <= WIN_A;
            r_rsp_valid   <= 1'b0;
            r_a_rdata     <= '0;
            r_b_rdata     <= '0;
            r_a_err       <= 1'b0;
            r_b_err       <= 1'b0;
        end else begin
            r_rsp_valid <= w_grant;
            if (w_grant) r_last_winner <= w_grant_b ? WIN_B : WIN_A;

            if (w_grant_a) begin
                r_a_err <= w_misaligned;
                if (!w_misaligned && !w_we) r_a_rdata <= dm_rdata;
            end
            if (w_grant_b) begin
                r_b_err <= w_misaligned;
                if (!w_misaligned && !w_we) r_b_rdata <= dm_rdata;
            end

            if (b_valid && !w_grant_b) begin
                if (r_starve_cnt != '1) r_starve_cnt <= r_starve_cnt + CNT_W'(1);
            end else begin
                r_starve_cnt <= '0;
            end
        end
    end

    // One shared response strobe, steered by the port that won last cycle.
    assign a_rvalid = r_rsp_valid && (r_last_winner == WIN_A);
    assign b_rvalid = r_rsp_valid && (r_last_winner == WIN_B);
    assign a_rdata  = r_a_rdata;
    assign b_rdata  = r_b_rdata;
    assign a_err    = r_a_err;
    assign b_err    = r_b_err;

endmodule

// File: tb/tb_dm_arbiter.sv
// Self-checking bench for dm_arbiter: table-driven directed vectors, a reset
// corner case and randomized traffic against a behavioural model.
module tb_dm_arbiter;
    import dm_arbiter_pkg::*;

    localparam int unsigned LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        a_valid, a_we, b_valid, b_we;
    logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
    logic [2:0]  a_op, b_op;
    logic        a_ready, a_rvalid, a_err, b_ready, b_rvalid, b_err;
    logic [31:0] a_rdata, b_rdata;
    logic        dm_w, dm_r;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic [2:0]  dm_op;

    dm_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_op(a_op),
        .a_ready(a_ready), .a_rvalid(a_rvalid), .a_rdata(a_rdata), .a_err(a_err),
        .b_valid(b_valid), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_op(b_op),
        .b_ready(b_ready), .b_rvalid(b_rvalid), .b_rdata(b_rdata), .b_err(b_err),
        .dm_w(dm_w), .dm_r(dm_r), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_op(dm_op),
        .dm_rdata(dm_rdata)
    );

    always #5 clk = ~clk;

    // Word-granular data memory standing in for dm.
    logic [31:0] mem [0:255] = '{default: 32'h0};
    assign dm_rdata = mem[dm_addr[9:2]];
    always @(posedge clk) if (dm_w) mem[dm_addr[9:2]] <= dm_wdata;

    typedef struct {
        logic        v;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  op;
    } req_t;

    typedef struct {
        req_t       a;
        req_t       b;
        logic [3:0] exp;   // {a_ready, b_ready, dm_w, dm_r}
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] ref_mem [0:255];
    logic        e_a_rv, e_a_err, e_b_rv, e_b_err;
    logic [31:0] e_a_rd, e_b_rd;
    int          lost;
    logic        last_ga, last_gb;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic req_t mk(input logic v, input logic we, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [2:0] op);
        req_t r;
        r.v = v; r.we = we; r.addr = addr; r.wdata = wdata; r.op = op;
        return r;
    endfunction

    function automatic logic is_mis(input logic [2:0] op, input logic [31:0] addr);
        if (op == DM_OP_WD) return (addr % 4) != 0;
        if (op == DM_OP_HS || op == DM_OP_HU) return (addr % 2) != 0;
        return 1'b0;
    endfunction

    task automatic drive(input req_t a, input req_t b);
        a_valid = a.v; a_we = a.we; a_addr = a.addr; a_wdata = a.wdata; a_op = a.op;
        b_valid = b.v; b_we = b.we; b_addr = b.addr; b_wdata = b.wdata; b_op = b.op;
    endtask

    task automatic model_reset();
        e_a_rv = 0; e_a_err = 0; e_a_rd = '0;
        e_b_rv = 0; e_b_err = 0; e_b_rd = '0;
        lost = 0;
    endtask

    // One clock of traffic: check the combinational grant and the responses
    // owed from the previous cycle, then advance the model past the edge.
    task automatic step(input req_t a, input req_t b, input logic use_tbl,
                        input logic [3:0] tbl, input string tag);
        logic ga, gb, g, mis;
        req_t w;
        drive(a, b);
        @(negedge clk);
        ga  = a.v && !(b.v && lost >= int'(LIMIT));
        gb  = b.v && !ga;
        g   = ga || gb;
        w   = ga ? a : (gb ? b : mk(0, 0, 0, 0, 0));
        mis = g && is_mis(w.op, w.addr);

        check({tag, ".a_ready"},  a_ready,  ga);
        check({tag, ".b_ready"},  b_ready,  gb);
        check({tag, ".dm_w"},     dm_w,     g && w.we && !mis);
        check({tag, ".dm_r"},     dm_r,     g && !w.we && !mis);
        check({tag, ".dm_addr"},  dm_addr,  w.addr);
        check({tag, ".dm_wdata"}, dm_wdata, w.wdata);
        check({tag, ".dm_op"},    dm_op,    w.op);
        if (use_tbl) check({tag, ".tbl"}, {a_ready, b_ready, dm_w, dm_r}, tbl);
        check({tag, ".a_rvalid"}, a_rvalid, e_a_rv);
        check({tag, ".a_rdata"},  a_rdata,  e_a_rd);
        check({tag, ".a_err"},    a_err,    e_a_err);
        check({tag, ".b_rvalid"}, b_rvalid, e_b_rv);
        check({tag, ".b_rdata"},  b_rdata,  e_b_rd);
        check({tag, ".b_err"},    b_err,    e_b_err);

        e_a_rv = ga;
        e_b_rv = gb;
        if (ga) begin
            e_a_err = mis;
            if (!mis && !w.we) e_a_rd = ref_mem[w.addr[9:2]];
        end
        if (gb) begin
            e_b_err = mis;
            if (!mis && !w.we) e_b_rd = ref_mem[w.addr[9:2]];
        end
        if (g && !mis && w.we) ref_mem[w.addr[9:2]] = w.wdata;
        lost = (b.v && !gb) ? ((lost < 15) ? lost + 1 : 15) : 0;
        last_ga = ga;
        last_gb = gb;
        @(posedge clk);
        #1;
    endtask

    function automatic req_t rand_req();
        logic [2:0] ops [5];
        ops = '{DM_OP_WD, DM_OP_BS, DM_OP_BU, DM_OP_HS, DM_OP_HU};
        return mk(1'b1, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 63)),
                  $urandom, ops[$urandom_range(0, 4)]);
    endfunction

    initial begin
        vec_t tbl[$];
        vec_t v;
        req_t idle, ard4, ard8, bwr8, pa, pb;
        logic pa_pend, pb_pend;

        idle = mk(0, 0, 0, 0, DM_OP_WD);
        ard4 = mk(1, 0, 4, 0, DM_OP_WD);
        ard8 = mk(1, 0, 8, 0, DM_OP_WD);
        bwr8 = mk(1, 1, 8, 2433, DM_OP_WD);
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
        model_reset();

        // Requests present while reset is held must not be accepted.
        drive(ard4, bwr8);
        #3;
        check("rst.a_ready",  a_ready,  0);
        check("rst.b_ready",  b_ready,  0);
        check("rst.dm_w",     dm_w,     0);
        check("rst.dm_r",     dm_r,     0);
        check("rst.a_rvalid", a_rvalid, 0);
        check("rst.b_rvalid", b_rvalid, 0);
        check("rst.a_rdata",  a_rdata,  0);
        check("rst.b_err",    b_err,    0);
        drive(idle, idle);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        v.a = mk(1, 1, 4, 2333, DM_OP_WD); v.b = idle; v.exp = 4'b1010; tbl.push_back(v);
        v.a = ard4; v.b = idle; v.exp = 4'b1001; tbl.push_back(v);
        for (int i = 0; i < 8; i++) begin
            v.a = ard4; v.b = bwr8; v.exp = (i == 4) ? 4'b0110 : 4'b1001;
            tbl.push_back(v);
        end
        v.a = ard8; v.b = idle; v.exp = 4'b1001; tbl.push_back(v);
        v.a = mk(1, 1, 6, 32'hDEAD, DM_OP_WD); v.b = idle; v.exp = 4'b1000; tbl.push_back(v);
        v.a = ard4; v.b = idle; v.exp = 4'b1001; tbl.push_back(v);
        v.a = idle; v.b = ard4; v.exp = 4'b0101; tbl.push_back(v);
        v.a = idle; v.b = ard8; v.exp = 4'b0101; tbl.push_back(v);
        for (int i = 0; i < 11; i++) begin
            v.a = idle; v.b = idle; v.exp = 4'b0000; tbl.push_back(v);
        end
        for (int i = 0; i < int'(tbl.size()); i++)
            step(tbl[i].a, tbl[i].b, 1'b1, tbl[i].exp, $sformatf("tbl%0d", i));

        // Build up starvation, then reset between a read's handshake and its response.
        for (int i = 0; i < 3; i++) step(ard4, ard8, 1'b0, 4'b0, "pre_rst");
        drive(ard4, idle);
        @(negedge clk);
        check("rst_mid.a_ready", a_ready, 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("rst_mid.a_rvalid", a_rvalid, 0);
        check("rst_mid.a_rdata",  a_rdata,  0);
        check("rst_mid.a_err",    a_err,    0);
        check("rst_mid.b_rvalid", b_rvalid, 0);
        check("rst_mid.b_rdata",  b_rdata,  0);
        check("rst_mid.a_ready",  a_ready,  0);
        check("rst_mid.dm_r",     dm_r,     0);
        drive(idle, idle);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        for (int i = 0; i < 6; i++)
            step(ard4, ard8, 1'b1, (i == 4) ? 4'b0101 : 4'b1001, $sformatf("post_rst%0d", i));
        step(ard4, idle, 1'b1, 4'b1001, "post_rst_done");

        pa_pend = 0;
        pb_pend = 0;
        pa = idle;
        pb = idle;
        for (int i = 0; i < 400; i++) begin
            if (!pa_pend) begin
                if ($urandom_range(0, 3) != 0) begin pa = rand_req(); pa_pend = 1; end
                else pa = idle;
            end
            if (!pb_pend) begin
                if ($urandom_range(0, 3) != 0) begin pb = rand_req(); pb_pend = 1; end
                else pb = idle;
            end
            step(pa, pb, 1'b0, 4'b0, $sformatf("rnd%0d", i));
            if (last_ga) pa_pend = 0;
            if (last_gb) pb_pend = 0;
        end
        step(idle, idle, 1'b1, 4'b0000, "final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
